// File: rtl/timer_rx.sv
// Receive-side bit/byte timer: locks to line edges, strobes once per bit at mid-bit,
// drops stuffed bits, flags stuff errors and marks each completed byte.
module timer_rx #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_PHASE  = 3,
  parameter int BITS_PER_BYTE = 8,
  parameter int STUFF_LIMIT   = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable_timer,
  input  logic d_edge,
  input  logic d_orig,
  output logic shift_enable,
  output logic byte_received,
  output logic stuff_error
);

  localparam int PH_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BC_W = $clog2(BITS_PER_BYTE + 1);
  localparam int OC_W = $clog2(STUFF_LIMIT + 1);

  localparam logic [PH_W-1:0] PH_ZERO   = '0;
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BITS_PER_BYTE - 1);
  localparam logic [OC_W-1:0] OC_LIMIT  = OC_W'(STUFF_LIMIT);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    WAIT_EDGE = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [OC_W-1:0] ones_cnt_q, ones_cnt_d;
  logic            shift_q, shift_d;
  logic            byte_q, byte_d;
  logic            serr_q, serr_d;
  logic            sample_cycle;

  assign sample_cycle = (state_q == RUN) && (phase_q == PH_SAMPLE) && enable_timer;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= OFF;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      ones_cnt_q <= '0;
      shift_q    <= 1'b0;
      byte_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      serr_q     <= serr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    ones_cnt_d = ones_cnt_q;
    shift_d    = 1'b0;
    byte_d     = 1'b0;
    serr_d     = 1'b0;

    if (!enable_timer) begin
      state_d    = OFF;
      phase_d    = '0;
      bit_cnt_d  = '0;
      ones_cnt_d = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d = WAIT_EDGE;
          phase_d = '0;
        end
        WAIT_EDGE: begin
          phase_d = '0;
          if (d_edge) begin
            state_d = RUN;
            phase_d = PH_ONE;
          end
        end
        RUN: begin
          phase_d = (phase_q == PH_LAST) ? PH_ZERO : phase_q + PH_ONE;
          // Edges inside 1..SAMPLE_PHASE are early; honouring them could skip a sample.
          if (d_edge && ((phase_q == PH_ZERO) || (phase_q > PH_SAMPLE))) begin
            phase_d = PH_ONE;
          end
          if (sample_cycle) begin
            if (ones_cnt_q == OC_LIMIT) begin
              ones_cnt_d = '0;
              serr_d     = d_orig;
            end else begin
              shift_d    = 1'b1;
              ones_cnt_d = d_orig ? ones_cnt_q + OC_W'(1) : '0;
              if (bit_cnt_q == BC_LAST) begin
                byte_d    = 1'b1;
                bit_cnt_d = '0;
              end else begin
                bit_cnt_d = bit_cnt_q + BC_W'(1);
              end
            end
          end
        end
        default: begin
          state_d = OFF;
          phase_d = '0;
        end
      endcase
    end
  end

  assign shift_enable  = shift_q;
  assign byte_received = byte_q;
  assign stuff_error   = serr_q;

endmodule

// File: tb/tb_timer_rx.sv
// Directed bench for timer_rx: strobe cycle numbers are logged relative to the
// locking edge and compared against hand-computed lists.
module tb_timer_rx;

  logic clk = 1'b0;
  logic n_rst;
  logic enable_timer;
  logic d_edge;
  logic d_orig;
  logic shift_enable;
  logic byte_received;
  logic stuff_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;
  int se_q[$];
  int br_q[$];
  int er_q[$];
  int exp_se[$];
  int exp_br[$];
  int exp_er[$];

  timer_rx #(
    .CLKS_PER_BIT (8),
    .SAMPLE_PHASE (3),
    .BITS_PER_BYTE(8),
    .STUFF_LIMIT  (6)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .d_edge       (d_edge),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .stuff_error  (stuff_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (shift_enable === 1'b1)  se_q.push_back(cyc - base);
    if (byte_received === 1'b1) br_q.push_back(cyc - base);
    if (stuff_error === 1'b1)   er_q.push_back(cyc - base);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic check_list(input string tag, input int got[$], input int exp[$]);
    check($sformatf("%s.count", tag), got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_all();
    se_q.delete(); br_q.delete(); er_q.delete();
    exp_se.delete(); exp_br.delete(); exp_er.delete();
  endtask

  // Disable for one cycle, re-enable, then lock with an edge; the edge cycle becomes base.
  task automatic start_stream();
    enable_timer = 1'b0;
    d_edge       = 1'b0;
    d_orig       = 1'b0;
    tick();
    enable_timer = 1'b1;
    tick();
    clear_all();
    base   = cyc;
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
  endtask

  // Holds bit k of the pattern on d_orig for the whole k-th bit window.
  task automatic run_bits(input logic [31:0] bits, input int nbits);
    int idx;
    for (int i = 0; i < nbits * 8; i++) begin
      idx    = (cyc - base) / 8;
      d_orig = (idx < 32) ? bits[idx] : 1'b0;
      tick();
    end
    d_orig = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_list({tag, ".se"}, se_q, exp_se);
    check_list({tag, ".br"}, br_q, exp_br);
    check_list({tag, ".er"}, er_q, exp_er);
  endtask

  initial begin
    n_rst        = 1'b0;
    enable_timer = 1'b0;
    d_edge       = 1'b0;
    d_orig       = 1'b0;
    #12;
    check("rst.shift_enable", 32'(shift_enable), 0);
    check("rst.byte_received", 32'(byte_received), 0);
    check("rst.stuff_error", 32'(stuff_error), 0);
    n_rst = 1'b1;
    tick();
    clear_all();
    d_edge = 1'b1;
    run(3);
    d_edge = 1'b0;
    run(10);
    check("off.no_strobes", se_q.size() + br_q.size() + er_q.size(), 0);

    // Free-running: sample every 8 cycles from cycle 3, strobes one cycle later.
    start_stream();
    run(124);
    for (int k = 0; k < 16; k++) exp_se.push_back(4 + 8 * k);
    exp_br.push_back(60);
    exp_br.push_back(124);
    check_all("freerun");

    // Resync at phase 6 (honoured), then an early edge at phase 2 (ignored).
    start_stream();
    run(5);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    tick();
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    run(10);
    exp_se.push_back(4);
    exp_se.push_back(10);
    exp_se.push_back(18);
    check_all("resync");

    // Six 1s then a stuffed 0: the 7th sample is dropped, byte ends on the 9th sample.
    start_stream();
    run_bits(32'h0000_003F, 10);
    for (int k = 0; k < 10; k++) if (k != 6) exp_se.push_back(4 + 8 * k);
    exp_br.push_back(68);
    check_all("unstuff");

    // Seven 1s -> stuff error on sample 6; six more 1s then a valid stuff 0.
    start_stream();
    run_bits(32'h0000_1FFF, 15);
    for (int k = 0; k < 15; k++) if (k != 6 && k != 13) exp_se.push_back(4 + 8 * k);
    exp_br.push_back(68);
    exp_er.push_back(52);
    check_all("stufferr");

    // Disable after five bits; the partial byte must be discarded.
    start_stream();
    run(36);
    check("partial.se_count", se_q.size(), 5);
    start_stream();
    run(60);
    for (int k = 0; k < 8; k++) exp_se.push_back(4 + 8 * k);
    exp_br.push_back(60);
    check_all("rebyte");

    // Asynchronous reset while a strobe is high.
    start_stream();
    run(3);
    check("arst.pre_shift", 32'(shift_enable), 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst.shift_enable", 32'(shift_enable), 0);
    check("arst.byte_received", 32'(byte_received), 0);
    check("arst.stuff_error", 32'(stuff_error), 0);
    #2;
    n_rst = 1'b1;
    clear_all();
    run(20);
    check("arst.idle_strobes", se_q.size() + br_q.size() + er_q.size(), 0);
    clear_all();
    base   = cyc;
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    run(4);
    exp_se.push_back(4);
    check_all("arst.relock");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
